i2c_target_regfile: RTL
=======================

Name: i2c_target_regfile

Overview:
- I2C target (slave) that sits directly downstream of the team's I2C master on the shared SCL/SDA bus.
- Decodes the master's address and write frames into a small register file and serves read frames back from it.
- Used as the on-chip loopback partner for the master in bench and silicon bring-up.
- Oversampled design: SCL and SDA are sampled on the system clock; no logic runs on SCL edges.

Parameters:
- TARGET_ADDR, 7'h2A, 7-bit address this target responds to.
- NUM_REGS, 4, register count; must be a power of two, 2..16.
- PTR_W, 2, pointer width; equals log2(NUM_REGS).

Ports:
- clk  input  1  system clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- scl_i  input  1  raw bus SCL, asynchronous to clk.
- sda_i  input  1  raw bus SDA, asynchronous to clk.
- sda_oe  output  1  1 = drive SDA low (open drain); 0 = release.
- reg_wr_en  output  1  one-cycle pulse when a data byte is committed.
- reg_wr_addr  output  PTR_W  register index of the committed byte.
- reg_wr_data  output  8  committed byte.
- busy  output  1  high from an addressed START (address match) until STOP.
- dbg_addr  input  PTR_W  debug read index.
- dbg_data  output  8  combinational read of regs[dbg_addr].

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - All outputs 0; regs and pointer cleared to 0; state = IDLE.
  - Applies mid-frame too: sda_oe is released on the next edge.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-flop synchronizer, then a 1-flop history register.
  - Edge and condition detect therefore lags the bus by 3 clk.
- Bus events (using synchronized values):
  - SCL rise = previous 0, now 1; SCL fall = previous 1, now 0.
  - START = SDA falls while SCL is 1; STOP = SDA rises while SCL is 1.
  - Data bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall (or on STOP/reset).
- States and transitions:
  - IDLE: START -> ADDR.
  - ADDR: shift 8 bits (7 address + R/W).
    - Address match -> ADDR_ACK.
    - Mismatch -> IGNORE; sda_oe stays 0.
  - ADDR_ACK: drive ACK for one SCL period.
    - Then W -> PTR, or R -> RDATA with the shift register loaded from regs[ptr].
  - PTR: first written byte -> ptr <= byte[PTR_W-1:0] (upper bits ignored) -> PTR_ACK -> WDATA.
  - WDATA: on the 8th bit, pulse reg_wr_en with reg_wr_addr = ptr; write regs[ptr]; ptr <= ptr+1 mod NUM_REGS. Then WDATA_ACK -> WDATA.
  - RDATA: drive the bits (sda_oe = ~bit), then RACK.
    - RACK: release SDA and sample the master's ACK on SCL rise.
    - ACK (SDA=0) -> ptr+1, reload the shift register, return to RDATA.
    - NACK -> IGNORE.
  - IGNORE: wait for START or STOP.
- Global rules:
  - STOP in any state -> IDLE, sda_oe=0, busy=0, ptr retained.
  - START in any state (repeated START) -> ADDR, ptr retained.
  - A START/STOP mid-byte discards that partial byte; no write is committed.
- reg_wr_en fires on the clk after the 8th SCL rise is detected; it is never high for two consecutive cycles.
- Simultaneous SCL and SDA change: SCL edge processing takes priority; no START/STOP is flagged that cycle.
- No clock stretching; the target never drives SCL.

Test Plan:
- Write, address 0x2A: START, 0x54, ptr 0x01, data 0x55, STOP.
  - ACK on all three bytes; one reg_wr_en with addr=1, data=0x55.
  - dbg_addr=1 -> dbg_data=0x55; busy falls after STOP.
- Address mismatch: START, 0x56 (0x2B, W), 0xAA, STOP.
  - sda_oe never asserts; no reg_wr_en; regs unchanged.
- Burst write with wrap: ptr 0x03, data 0x11, 0x22.
  - regs[3]=0x11, regs[0]=0x22; ptr ends at 1.
- Read after repeated START: write ptr 0x01, repeated START, 0x55 (R); master ACKs the first byte, NACKs the second.
  - Bytes driven: 0x55 then regs[2]; SDA released after the NACK; STOP -> IDLE.
- Reset mid-read: assert rst while the target is driving a 0 bit.
  - sda_oe=0 on the next clk; regs = 0; the next valid write frame succeeds.
- Truncated byte: START, 0x54, ptr 0x00, 4 data bits, STOP.
  - No reg_wr_en; regs[0] unchanged.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a small register file, oversampled on clk.
// Write frames set a pointer then fill registers; read frames stream them back.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         NUM_REGS    = 4,
    parameter int         PTR_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             reg_wr_en,
    output logic [PTR_W-1:0] reg_wr_addr,
    output logic [7:0]       reg_wr_data,
    output logic             busy,
    input  logic [PTR_W-1:0] dbg_addr,
    output logic [7:0]       dbg_data
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } state_t;

    state_t           state, state_n;
    logic             scl_s1, scl_s2, scl_h;
    logic             sda_s1, sda_s2, sda_h;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             rw, rw_n;
    logic             sda_oe_n, busy_n, wr_en_n;
    logic [PTR_W-1:0] wr_addr_n;
    logic [7:0]       wr_data_n;
    logic [7:0]       regs [NUM_REGS];

    logic             scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]       byte_in, rd_byte;

    // Synchronizers reset to the idle-high bus level so no spurious START/STOP appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    // SDA edges only count as START/STOP while SCL is steadily high.
    assign scl_rise  = ~scl_h & scl_s2;
    assign scl_fall  = scl_h & ~scl_s2;
    assign start_det = sda_h & ~sda_s2 & scl_h & scl_s2;
    assign stop_det  = ~sda_h & sda_s2 & scl_h & scl_s2;

    assign byte_in  = {shift[6:0], sda_s2};
    assign rd_byte  = regs[ptr];
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            ptr         <= ptr_n;
            rw          <= rw_n;
            sda_oe      <= sda_oe_n;
            busy        <= busy_n;
            reg_wr_en   <= wr_en_n;
            reg_wr_addr <= wr_addr_n;
            reg_wr_data <= wr_data_n;
            if (wr_en_n) begin
                regs[ptr] <= wr_data_n;
            end
        end
    end

    // In ACK states bit_cnt marks whether the ninth SCL rise has been seen yet.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        rw_n      = rw;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        wr_en_n   = 1'b0;
        wr_addr_n = reg_wr_addr;
        wr_data_n = reg_wr_data;

        if (stop_det) begin
            state_n   = IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
        end else if (start_det) begin
            state_n   = ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            if (state == ADDR) begin
                                if (byte_in[7:1] == TARGET_ADDR) begin
                                    state_n = ADDR_ACK;
                                    rw_n    = byte_in[0];
                                    busy_n  = 1'b1;
                                end else begin
                                    state_n = IGNORE;
                                end
                            end else if (state == PTR) begin
                                ptr_n   = byte_in[PTR_W-1:0];
                                state_n = PTR_ACK;
                            end else begin
                                wr_en_n   = 1'b1;
                                wr_addr_n = ptr;
                                wr_data_n = byte_in;
                                ptr_n     = ptr + PTR_W'(1);
                                state_n   = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_n = 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && rw) begin
                                state_n  = RDATA;
                                shift_n  = rd_byte;
                                sda_oe_n = ~rd_byte[7];
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n   = RACK;
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                        end else begin
                            sda_oe_n = ~shift[7];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s2) begin
                            ptr_n     = ptr + PTR_W'(1);
                            bit_cnt_n = 4'd1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_n = '0;
                        state_n   = RDATA;
                        shift_n   = rd_byte;
                        sda_oe_n  = ~rd_byte[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
